// File: rtl/my_dff_stage.sv
// my_dff_stage: one WIDTH-bit D flop with synchronous, active-high reset.
// This is the single-stage building block that my_dff_reg chains into a
// pipeline.
//
// Ports:
//   toggle - clock; the flop updates on its rising edge
//   reset  - synchronous, active-high; loads RESET_VALUE and wins over d
//   d      - data in, sampled on the rising edge of toggle
//   q      - registered data out
module my_dff_stage #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             toggle,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Power-up value matches the reset value, so q is defined before the
  // first reset edge.
  logic [WIDTH-1:0] q_p0 = RESET_VALUE;

  always_ff @(posedge toggle) begin
    if (reset) q_p0 <= RESET_VALUE;
    else       q_p0 <= d;
  end

  assign q = q_p0;

endmodule

// File: rtl/my_dff_reg.sv
// my_dff_reg: output-staging register for the scoreboard clock counters.
// STAGES cascaded WIDTH-bit flops; q is driven straight from the last stage,
// so a d value sampled at edge n is visible on q after edge n+STAGES-1.
// Reset is synchronous and flushes every stage to RESET_VALUE.
//
// Parameters:
//   WIDTH       - data width, 1..64
//   RESET_VALUE - value loaded into every stage on reset (and at power-up)
//   STAGES      - number of register stages (latency in edges), 1..8
//
// Ports (positional order is fixed: toggle, reset, d, q):
//   toggle - clock, rising edge active
//   reset  - synchronous, active-high
//   d      - data in
//   q      - data out from the last stage
module my_dff_reg #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      STAGES      = 1
) (
  input  logic             toggle,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "my_dff_reg: WIDTH=%0d outside 1..64", WIDTH);
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "my_dff_reg: STAGES=%0d outside 1..8", STAGES);
  end

  // s[k] is the output of stage k; stage 0 takes d, stage k takes s[k-1].
  logic [STAGES-1:0][WIDTH-1:0] s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    if (k == 0) begin : g_first
      assign stage_in = d;
    end else begin : g_chain
      assign stage_in = s[k-1];
    end

    my_dff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .toggle (toggle),
      .reset  (reset),
      .d      (stage_in),
      .q      (s[k])
    );
  end

  assign q = s[STAGES-1];

`ifndef SYNTHESIS
  // Edges since the last reset edge, saturating; 0 at power-up so the
  // latency check waits for a fully reset-and-refilled pipeline.
  logic [3:0] since_rst = '0;

  always_ff @(posedge toggle) begin
    if (reset)                   since_rst <= '0;
    else if (since_rst != 4'hF)  since_rst <= since_rst + 4'd1;
  end

  a_q_known: assert property (@(posedge toggle) !$isunknown(q));

  // Value seen on q at edge m was captured from d at edge m-STAGES,
  // provided no reset hit any of the intervening edges.
  a_latency: assert property (@(posedge toggle)
    (since_rst >= 4'(STAGES)) |-> (q == $past(d, STAGES)));
`endif

endmodule

// File: tb/tb_my_dff_reg.sv
module tb_my_dff_reg;

  logic toggle = 1'b0;
  always #5 toggle = ~toggle;

  // Default configuration: 1 bit, 1 stage, reset value 0.
  logic       rst0 = 1'b0;
  logic       d0   = 1'b0;
  logic       q0;
  // 10-bit counter staging.
  logic       rst10 = 1'b0;
  logic [9:0] d10   = '0;
  logic [9:0] q10;
  // 4-bit, 3-stage pipeline with reset value A.
  logic       rst4 = 1'b0;
  logic [3:0] d4   = '0;
  logic [3:0] q4;

  my_dff_reg u_dff0 (
    .toggle (toggle),
    .reset  (rst0),
    .d      (d0),
    .q      (q0)
  );

  my_dff_reg #(.WIDTH(10)) u_dff10 (
    .toggle (toggle),
    .reset  (rst10),
    .d      (d10),
    .q      (q10)
  );

  my_dff_reg #(.WIDTH(4), .RESET_VALUE(4'hA), .STAGES(3)) u_dff4 (
    .toggle (toggle),
    .reset  (rst4),
    .d      (d4),
    .q      (q4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge toggle);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up, before any edge or reset.
    #1;
    chk("pwrup_q0",  64'(q0),  64'd0);
    chk("pwrup_q10", 64'(q10), 64'd0);
    chk("pwrup_q4",  64'(q4),  64'hA);

    // Reset held for two edges with d=1, then release.
    rst0 = 1'b1; d0 = 1'b1;
    tick(); chk("rst_edge1", 64'(q0), 64'd0);
    tick(); chk("rst_edge2", 64'(q0), 64'd0);
    rst0 = 1'b0;
    tick(); chk("rst_release", 64'(q0), 64'd1);

    // d wiggles between edges; q holds.
    d0 = 1'b0; #1 d0 = 1'b1; #1 d0 = 1'b0; #1;
    chk("hold", 64'(q0), 64'd1);
    tick(); chk("sample0", 64'(q0), 64'd0);

    // Reset beats d on the same edge.
    rst0 = 1'b1; d0 = 1'b1;
    tick(); chk("prio_rst", 64'(q0), 64'd0);
    rst0 = 1'b0;
    tick(); chk("prio_after", 64'(q0), 64'd1);

    // 10-bit counter countdown.
    rst10 = 1'b1;
    tick(); chk("w10_rst", 64'(q10), 64'd0);
    rst10 = 1'b0;
    d10 = 10'd600; tick(); chk("w10_600", 64'(q10), 64'd600);
    d10 = 10'd599; tick(); chk("w10_599", 64'(q10), 64'd599);
    d10 = 10'd598; tick(); chk("w10_598", 64'(q10), 64'd598);
    rst10 = 1'b1; d10 = 10'd599;
    tick(); chk("w10_rst2", 64'(q10), 64'd0);
    rst10 = 1'b0;

    // Three-stage pipeline fill.
    rst4 = 1'b1;
    tick(); chk("p3_rst", 64'(q4), 64'hA);
    rst4 = 1'b0;
    d4 = 4'd1; tick(); chk("p3_e1", 64'(q4), 64'hA);
    d4 = 4'd2; tick(); chk("p3_e2", 64'(q4), 64'hA);
    d4 = 4'd3; tick(); chk("p3_e3", 64'(q4), 64'd1);
    d4 = 4'd4; tick(); chk("p3_e4", 64'(q4), 64'd2);
    d4 = 4'd5; tick(); chk("p3_e5", 64'(q4), 64'd3);
    d4 = 4'd6; tick(); chk("p3_e6", 64'(q4), 64'd4);

    // Reset with 6,5 in flight: they must never emerge.
    rst4 = 1'b1; d4 = 4'd7;
    tick(); chk("p3_flush", 64'(q4), 64'hA);
    rst4 = 1'b0;
    d4 = 4'd8; tick(); chk("p3_refill1", 64'(q4), 64'hA);
    d4 = 4'd9; tick(); chk("p3_refill2", 64'(q4), 64'hA);
    d4 = 4'd0; tick(); chk("p3_out8", 64'(q4), 64'd8);
    tick();            chk("p3_out9", 64'(q4), 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
